// File: rtl/gray_counter_updown.sv
// Parametrised up/down binary-reflected Gray counter with parallel load.
// A single binary register holds the count state. The Gray view is registered
// from the same next value, so count and count_bin change on the same edge.
// wrap pulses for one cycle together with the post-wrap value.
module gray_counter_updown #(
    parameter int WIDTH     = 3,
    parameter int RESET_BIN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bin,
    output logic             wrap
);

    // Stop elaboration on an illegal width or an unreachable reset value
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("gray_counter_updown: WIDTH=%0d outside 2..16", WIDTH);
    end
    if (RESET_BIN < 0 || RESET_BIN >= (1 << WIDTH)) begin : g_bad_reset
        $error("gray_counter_updown: RESET_BIN=%0d not representable in %0d bits",
               RESET_BIN, WIDTH);
    end

    localparam logic [WIDTH-1:0] RST_BIN  = RESET_BIN[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // Next binary value and wrap flag; load beats counting, idle holds
    always_comb begin
        bin_next  = count_bin;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            if (up) begin
                bin_next  = count_bin + ONE;
                wrap_next = (count_bin == ALL_ONES);
            end else begin
                bin_next  = count_bin - ONE;
                wrap_next = (count_bin == ZERO);
            end
        end
    end

    // Gray encoding of the next value, so the Gray output never lags the binary one
    always_comb begin
        gray_next = bin_next ^ (bin_next >> 1);
    end

    // Output registers with asynchronous reset to the configured start value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_bin <= RST_BIN;
            count     <= RST_GRAY;
            wrap      <= 1'b0;
        end else begin
            count_bin <= bin_next;
            count     <= gray_next;
            wrap      <= wrap_next;
        end
    end

endmodule

// File: doc/gray_counter_updown.md
Name: gray_counter_updown

Overview:
Parametrised binary-reflected Gray counter. It is the successor to the fixed 3-bit modulo-8 Gray counter and adds configurable width, enable, up/down direction, parallel load, a binary-view output and a wrap indication. It is used for clock-domain-crossing pointers and for low-toggle sequencing in the exercise designs. One clock domain; all outputs are registered.

Parameters:
WIDTH, 3, counter width in bits; legal range 2..16; modulus is 2**WIDTH.
RESET_BIN, 0, binary value loaded on reset; must be < 2**WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
en  input  1  count enable; advances one step per clk when high
up  input  1  direction: 1 = increment, 0 = decrement (binary sense)
load  input  1  synchronous parallel load; takes priority over en
load_bin  input  WIDTH  binary value captured when load=1
count  output  WIDTH  Gray-coded count, registered
count_bin  output  WIDTH  binary equivalent of count, registered, same cycle
wrap  output  1  one-cycle pulse after a wrap-around step

Behaviour:
- Reset behaviour:
  - Reset is asynchronous and active-high. Clock is clk, reset is rst. Both are fixed.
  - While rst=1: count_bin = RESET_BIN, count = RESET_BIN ^ (RESET_BIN >> 1), wrap = 0.
  - Release is sampled at the next rising clk edge. The first count step can occur on the first edge where rst=0 and en=1.
- State:
  - One WIDTH-bit binary register b drives count_bin.
  - count is registered from the next value: count <= b_next ^ (b_next >> 1).
  - count never lags count_bin. No extra pipeline cycle; latency from en to output change is 1 clk.
- Priority, per rising edge with rst=0:
  1. load=1: b <= load_bin, wrap <= 0. en and up are ignored.
  2. else en=1, up=1: b <= b + 1 mod 2**WIDTH. wrap <= 1 iff b was 2**WIDTH-1.
  3. else en=1, up=0: b <= b - 1 mod 2**WIDTH. wrap <= 1 iff b was 0.
  4. else: hold b, wrap <= 0.
- Gray property: every count/step, including the wrap steps, changes exactly one bit of count. Load and reset may change any number of bits.
- Direction change: takes effect on the same edge it is sampled. No dead cycle. Reversing direction retraces the Gray sequence exactly.
- wrap:
  - High for exactly one cycle, coincident with the post-wrap value on count.
  - Never asserted by load or reset.
  - Continuous counting asserts it once every 2**WIDTH enabled cycles.
- Reset mid-operation: outputs go to reset values immediately, without waiting for clk. A pending wrap pulse is cleared.
- Arithmetic: modulo 2**WIDTH; no saturation. Unused upper bits of load_bin do not exist (the width is exact).
- Illegal parameters (WIDTH < 2, or RESET_BIN out of range) are flagged by an elaboration-time check.

Test Plan:
- WIDTH=3. Assert rst, release at a negedge, then 8 cycles with en=1, up=1 -> count = 001,011,010,110,111,101,100,000. count_bin = 1..7,0. wrap=1 only on the cycle showing 000.
- From 000, up=0, en=1 for 2 cycles -> count 100 (bin 7) with wrap=1, then 101 (bin 6) with wrap=0.
- load=1, load_bin=5, en=1, up=1 in the same cycle -> next cycle count_bin=5, count=111, wrap=0. The count step is ignored.
- en=0 for 5 cycles at count=110 -> count stays 110 and wrap stays 0. Then toggle up every cycle with en=1 -> count alternates 110/111.
- Assert rst asynchronously between edges mid-count at count_bin=6 -> count=000, count_bin=0 and wrap=0 before the next clk edge. Counting resumes from 0 after release.
- WIDTH=4, RESET_BIN=9. After reset count=1101. Run 32 up-cycles -> check a single-bit Hamming distance between consecutive counts, and check wrap pulses exactly twice.
